// File: rtl/cu_pkg.sv
// Shared opcodes, T-states and control-word layout for the bus processor sequencer.
// Conditional jumps are built only when CU_COND_JUMP_EN is defined.
package cu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam int CW_PC_EN   = 0;
  localparam int CW_PC_INC  = 1;
  localparam int CW_PC_LD   = 2;
  localparam int CW_MAR_LD  = 3;
  localparam int CW_RAM_EN  = 4;
  localparam int CW_RAM_LD  = 5;
  localparam int CW_IR_LD   = 6;
  localparam int CW_IR_EN   = 7;
  localparam int CW_A_LD    = 8;
  localparam int CW_A_EN    = 9;
  localparam int CW_B_LD    = 10;
  localparam int CW_ALU_EN  = 11;
  localparam int CW_ALU_SUB = 12;
  localparam int CW_FLAGS   = 13;
  localparam int CW_OUT_LD  = 14;
  localparam int CW_W       = 15;

  typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational map of (step, opcode, flags) to a control word and end-of-instruction flag.
// JC/JZ decode only when CU_COND_JUMP_EN is defined; otherwise they act as NOP.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [2:0]      step,
  input  logic [3:0]      opcode,
  input  logic            flag_carry,
  input  logic            flag_zero,
  output logic [CW_W-1:0] cw,
  output logic            last_step,
  output logic            hlt
);

`ifndef CU_COND_JUMP_EN
  logic flags_unused;
  assign flags_unused = flag_carry ^ flag_zero;
`endif

  always_comb begin
    cw        = '0;
    last_step = 1'b0;
    hlt       = 1'b0;
    unique case (step)
      T0: begin
        cw[CW_PC_EN]  = 1'b1;
        cw[CW_MAR_LD] = 1'b1;
      end
      T1: begin
        cw[CW_RAM_EN] = 1'b1;
        cw[CW_IR_LD]  = 1'b1;
        cw[CW_PC_INC] = 1'b1;
      end
      default: begin
        // Steps past an instruction's final one fall back to ending it.
        last_step = 1'b1;
        unique case (opcode)
          OP_LDA, OP_STA: begin
            if (step == T2) begin
              cw[CW_IR_EN]  = 1'b1;
              cw[CW_MAR_LD] = 1'b1;
              last_step     = 1'b0;
            end else if (step == T3) begin
              if (opcode == OP_LDA) begin
                cw[CW_RAM_EN] = 1'b1;
                cw[CW_A_LD]   = 1'b1;
              end else begin
                cw[CW_A_EN]   = 1'b1;
                cw[CW_RAM_LD] = 1'b1;
              end
            end
          end
          OP_ADD, OP_SUB: begin
            if (step == T2) begin
              cw[CW_IR_EN]  = 1'b1;
              cw[CW_MAR_LD] = 1'b1;
              last_step     = 1'b0;
            end else if (step == T3) begin
              cw[CW_RAM_EN] = 1'b1;
              cw[CW_B_LD]   = 1'b1;
              last_step     = 1'b0;
            end else if (step == T4) begin
              cw[CW_ALU_EN]  = 1'b1;
              cw[CW_A_LD]    = 1'b1;
              cw[CW_FLAGS]   = 1'b1;
              cw[CW_ALU_SUB] = (opcode == OP_SUB);
            end
          end
          OP_LDI: begin
            cw[CW_IR_EN] = (step == T2);
            cw[CW_A_LD]  = (step == T2);
          end
          OP_JMP: begin
            cw[CW_IR_EN] = (step == T2);
            cw[CW_PC_LD] = (step == T2);
          end
`ifdef CU_COND_JUMP_EN
          OP_JC: begin
            cw[CW_IR_EN] = (step == T2) && flag_carry;
            cw[CW_PC_LD] = (step == T2) && flag_carry;
          end
          OP_JZ: begin
            cw[CW_IR_EN] = (step == T2) && flag_zero;
            cw[CW_PC_LD] = (step == T2) && flag_zero;
          end
`endif
          OP_OUT: begin
            cw[CW_A_EN]   = (step == T2);
            cw[CW_OUT_LD] = (step == T2);
          end
          OP_HLT: begin
            hlt       = (step == T2);
            last_step = (step != T2);
          end
          default: begin
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: T-state counter, halt latch and reset/halt gating of the control word.
// Build with CU_COND_JUMP_EN defined to enable JC/JZ.
module control_unit
  import cu_pkg::*;
#(
  parameter int MAX_STEPS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ir_opcode,
  input  logic       flag_carry,
  input  logic       flag_zero,
  output logic       pc_enable,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_enable,
  output logic       ram_load,
  output logic       ir_load,
  output logic       ir_enable,
  output logic       a_load,
  output logic       a_enable,
  output logic       b_load,
  output logic       alu_enable,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] step
);

  localparam int SW = $clog2(MAX_STEPS);
  localparam logic [SW-1:0] LAST = SW'(MAX_STEPS - 1);

  logic [SW-1:0]   cnt;
  logic [SW-1:0]   cnt_nxt;
  logic            halt_q;
  logic            halt_nxt;
  logic [CW_W-1:0] dec_cw;
  logic [CW_W-1:0] cw;
  logic            last_step;
  logic            hlt;

  assign step = 3'(cnt);

  cu_decoder u_dec (
    .step       (step),
    .opcode     (ir_opcode),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .cw         (dec_cw),
    .last_step  (last_step),
    .hlt        (hlt)
  );

  always_comb begin
    cnt_nxt  = cnt;
    halt_nxt = halt_q;
    if (!halt_q) begin
      if (hlt) begin
        halt_nxt = 1'b1;
      end else if (last_step || cnt == LAST) begin
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      halt_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      halt_q <= halt_nxt;
    end
  end

  // Gate on rst directly so strobes drop the instant reset asserts.
  assign cw     = (rst || halt_q) ? '0 : dec_cw;
  assign halted = halt_q;

  assign pc_enable  = cw[CW_PC_EN];
  assign pc_inc     = cw[CW_PC_INC];
  assign pc_load    = cw[CW_PC_LD];
  assign mar_load   = cw[CW_MAR_LD];
  assign ram_enable = cw[CW_RAM_EN];
  assign ram_load   = cw[CW_RAM_LD];
  assign ir_load    = cw[CW_IR_LD];
  assign ir_enable  = cw[CW_IR_EN];
  assign a_load     = cw[CW_A_LD];
  assign a_enable   = cw[CW_A_EN];
  assign b_load     = cw[CW_B_LD];
  assign alu_enable = cw[CW_ALU_EN];
  assign alu_sub    = cw[CW_ALU_SUB];
  assign flags_load = cw[CW_FLAGS];
  assign out_load   = cw[CW_OUT_LD];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit against a table-driven micro-op model.
// Honours CU_COND_JUMP_EN the same way as the design build.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ir_opcode = 4'h0;
  logic       flag_carry = 1'b0;
  logic       flag_zero = 1'b0;
  logic       pc_enable, pc_inc, pc_load, mar_load;
  logic       ram_enable, ram_load, ir_load, ir_enable;
  logic       a_load, a_enable, b_load;
  logic       alu_enable, alu_sub, flags_load, out_load;
  logic       halted;
  logic [2:0] step;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  control_unit #(.MAX_STEPS(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .ir_opcode  (ir_opcode),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .pc_enable  (pc_enable),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .mar_load   (mar_load),
    .ram_enable (ram_enable),
    .ram_load   (ram_load),
    .ir_load    (ir_load),
    .ir_enable  (ir_enable),
    .a_load     (a_load),
    .a_enable   (a_enable),
    .b_load     (b_load),
    .alu_enable (alu_enable),
    .alu_sub    (alu_sub),
    .flags_load (flags_load),
    .out_load   (out_load),
    .halted     (halted),
    .step       (step)
  );

  localparam logic [14:0] PCE  = 15'h4000;
  localparam logic [14:0] PCI  = 15'h2000;
  localparam logic [14:0] PCL  = 15'h1000;
  localparam logic [14:0] MARL = 15'h0800;
  localparam logic [14:0] RAME = 15'h0400;
  localparam logic [14:0] RAML = 15'h0200;
  localparam logic [14:0] IRL  = 15'h0100;
  localparam logic [14:0] IRE  = 15'h0080;
  localparam logic [14:0] AL   = 15'h0040;
  localparam logic [14:0] AE   = 15'h0020;
  localparam logic [14:0] BL   = 15'h0010;
  localparam logic [14:0] ALUE = 15'h0008;
  localparam logic [14:0] SUBS = 15'h0004;
  localparam logic [14:0] FL   = 15'h0002;
  localparam logic [14:0] OUTL = 15'h0001;

`ifdef CU_COND_JUMP_EN
  localparam bit CJ = 1'b1;
`else
  localparam bit CJ = 1'b0;
`endif

  logic [14:0] dut_cw;
  assign dut_cw = {pc_enable, pc_inc, pc_load, mar_load, ram_enable,
                   ram_load, ir_load, ir_enable, a_load, a_enable,
                   b_load, alu_enable, alu_sub, flags_load, out_load};

  function automatic int lat(logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [14:0] exp_cw(logic [3:0] op, int t, bit c, bit z);
    if (t == 0) return PCE | MARL;
    if (t == 1) return RAME | IRL | PCI;
    case (op)
      4'h1: return (t == 2) ? (IRE | MARL) : (RAME | AL);
      4'h2, 4'h3: begin
        if (t == 2) return IRE | MARL;
        if (t == 3) return RAME | BL;
        return ALUE | AL | FL | ((op == 4'h3) ? SUBS : 15'h0);
      end
      4'h4: return (t == 2) ? (IRE | MARL) : (AE | RAML);
      4'h5: return IRE | AL;
      4'h6: return IRE | PCL;
      4'h7: return (CJ && c) ? (IRE | PCL) : 15'h0;
      4'h8: return (CJ && z) ? (IRE | PCL) : 15'h0;
      4'hE: return AE | OUTL;
      default: return 15'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    int drivers;
    drivers = int'(pc_enable) + int'(ram_enable) + int'(ir_enable)
            + int'(a_enable) + int'(alu_enable);
    total++;
    if (drivers > 1) begin
      bad++;
      $display("FAIL bus_rule t=%0t drivers=%0d required<=1", $time, drivers);
    end
    total++;
    if (pc_load && pc_inc) begin
      bad++;
      $display("FAIL pc_ld_inc t=%0t pc_load=1 pc_inc=1 required not both", $time);
    end
  end

  // Runs one instruction starting at posedge+1 of its T0; ends at posedge+1 of the next T0.
  task automatic run_instr(input logic [3:0] op, input bit c, input bit z);
    logic [14:0] e;
    ir_opcode  = op;
    flag_carry = c;
    flag_zero  = z;
    for (int t = 0; t < lat(op); t++) begin
      @(negedge clk);
      e = exp_cw(op, t, c, z);
      total++;
      if (step !== 3'(t)) begin
        bad++;
        $display("FAIL step op=%h t=%0d got=%0d exp=%0d", op, t, step, t);
      end
      total++;
      if (dut_cw !== e) begin
        bad++;
        $display("FAIL cw op=%h t=%0d c=%0b z=%0b got=%h exp=%h", op, t, c, z, dut_cw, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ir_opcode = 4'h0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (dut_cw !== 15'h0 || step !== 3'd0 || halted !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cw=%h step=%0d halted=%b exp cw=0 step=0 halted=0",
                 dut_cw, step, halted);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (pc_enable !== 1'b1 || mar_load !== 1'b1 || step !== 3'd0) begin
      bad++;
      $display("FAIL reset_first_t0 pce=%b marl=%b step=%0d exp 1 1 0",
               pc_enable, mar_load, step);
    end
    @(posedge clk);
    #1;
    for (int t = 1; t < 3; t++) begin
      @(negedge clk);
      total++;
      if (dut_cw !== exp_cw(4'h0, t, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL reset_nop t=%0d got=%h exp=%h", t, dut_cw, exp_cw(4'h0, t, 1'b0, 1'b0));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ldi();
    run_instr(4'h5, 1'b0, 1'b0);
    run_instr(4'h5, 1'b1, 1'b1);
  endtask

  task automatic test_add_sub();
    run_instr(4'h2, 1'b0, 1'b0);
    run_instr(4'h3, 1'b0, 1'b0);
  endtask

  task automatic test_jz();
    run_instr(4'h8, 1'b0, 1'b1);
    run_instr(4'h8, 1'b1, 1'b0);
    run_instr(4'h7, 1'b1, 1'b0);
    run_instr(4'h7, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    run_instr(4'h1, 1'b0, 1'b0);
    run_instr(4'h4, 1'b0, 1'b0);
    run_instr(4'hE, 1'b0, 1'b0);
    run_instr(4'h6, 1'b0, 1'b0);
    run_instr(4'hA, 1'b0, 1'b0);
  endtask

  task automatic test_hlt();
    ir_opcode = 4'hF;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      total++;
      if (step !== 3'(t) || dut_cw !== exp_cw(4'hF, t, 1'b0, 1'b0) || halted !== 1'b0) begin
        bad++;
        $display("FAIL hlt_pre t=%0d step=%0d cw=%h halted=%b exp step=%0d cw=%h halted=0",
                 t, step, dut_cw, halted, t, exp_cw(4'hF, t, 1'b0, 1'b0));
      end
      @(posedge clk);
      #1;
    end
    repeat (10) begin
      ir_opcode = 4'($urandom);
      @(negedge clk);
      total++;
      if (halted !== 1'b1 || step !== 3'd2 || dut_cw !== 15'h0) begin
        bad++;
        $display("FAIL hlt_hold halted=%b step=%0d cw=%h exp 1 2 0", halted, step, dut_cw);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (halted !== 1'b0 || step !== 3'd0 || dut_cw !== 15'h0) begin
      bad++;
      $display("FAIL hlt_rst halted=%b step=%0d cw=%h exp 0 0 0", halted, step, dut_cw);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_add();
    ir_opcode = 4'h2;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (step !== 3'd3 || dut_cw !== (RAME | BL)) begin
      bad++;
      $display("FAIL mid_add_t3 step=%0d cw=%h exp step=3 cw=%h", step, dut_cw, RAME | BL);
    end
    rst = 1'b1;
    #1;
    total++;
    if (dut_cw !== 15'h0 || step !== 3'd0) begin
      bad++;
      $display("FAIL mid_add_rst cw=%h step=%0d exp cw=0 step=0", dut_cw, step);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(4'h5, 1'b0, 1'b0);
    run_instr(4'h3, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (step !== 3'd0 || dut_cw !== (PCE | MARL)) begin
      bad++;
      $display("FAIL final_t0 step=%0d cw=%h exp step=0 cw=%h", step, dut_cw, PCE | MARL);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add_sub();
    test_jz();
    test_back_to_back();
    test_random();
    test_hlt();
    test_reset_mid_add();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 8-bit bus processor. It steps through fetch and execute T-states and decodes the 4-bit opcode from the instruction register. Each cycle it drives one control word that strobes every register on the shared bus. It is the initiator side of the program counter handshake: it issues `pc_enable`, `pc_inc` and `pc_load`, and it issues the matching MAR, RAM, IR, A, B, ALU and output strobes.

## Interface
- `MAX_STEPS`, 5, T-states per instruction including fetch; legal range 3..8; sets the width of the step counter.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ir_opcode` in 4: opcode (upper IR nibble); sampled only from T2 onward.
- `flag_carry` in 1: registered carry flag.
- `flag_zero` in 1: registered zero flag.
- `pc_enable`, `pc_inc`, `pc_load` out 1 each: program counter strobes.
- `mar_load` out 1: memory address register load.
- `ram_enable`, `ram_load` out 1 each: RAM drive and write.
- `ir_load`, `ir_enable` out 1 each: IR load, and IR drive of the zero-extended operand.
- `a_load`, `a_enable`, `b_load` out 1 each: register strobes.
- `alu_enable`, `alu_sub`, `flags_load` out 1 each: ALU drive, subtract select, flag capture.
- `out_load` out 1: output register load.
- `halted` out 1: high once HLT executes.
- `step` out 3: current T-state, for debug.

## Operation
- State consists of a step counter (T0..MAX_STEPS-1) and a halt latch.
- Control outputs are decoded combinationally from `step`, `ir_opcode` and the flags. All are forced to 0 while `rst` is high or `halted` is high.
- Fetch:
  - T0: `pc_enable`, `mar_load`.
  - T1: `ram_enable`, `ir_load`, `pc_inc`.
- Execute, T2 onward. The last listed step of each instruction ends it, and the next cycle is T0:
  - 0000 NOP: T2 empty, end.
  - 0001 LDA: T2 `ir_enable mar_load`; T3 `ram_enable a_load`.
  - 0010 ADD: T2 `ir_enable mar_load`; T3 `ram_enable b_load`; T4 `alu_enable a_load flags_load`.
  - 0011 SUB: same as ADD, with `alu_sub` high in T4.
  - 0100 STA: T2 `ir_enable mar_load`; T3 `a_enable ram_load`.
  - 0101 LDI: T2 `ir_enable a_load`.
  - 0110 JMP: T2 `ir_enable pc_load`.
  - 0111 JC: T2 `ir_enable pc_load` only if `flag_carry`; otherwise T2 is empty.
  - 1000 JZ: T2 `ir_enable pc_load` only if `flag_zero`; otherwise T2 is empty.
  - 1110 OUT: T2 `a_enable out_load`.
  - 1111 HLT: T2 sets the halt latch at the clock edge; the counter then freezes.
  - All other opcodes behave as NOP.
- Bus rule: at most one of `pc_enable`, `ram_enable`, `ir_enable`, `a_enable`, `alu_enable` is high in any cycle.
- `pc_load` and `pc_inc` are never high in the same cycle.
- Early termination always wraps to T0. If an instruction would need a step ≥ MAX_STEPS, the counter wraps at MAX_STEPS-1 regardless.

## Timing
- Reset: `step`=0, `halted`=0, every control output 0 asynchronously. The first fetch (T0) is decoded in the first cycle after `rst` deasserts.
- A control word is valid for the whole cycle and is consumed by its target registers at the closing rising edge.
- Instruction latency:
  - 3 cycles: NOP, LDI, JMP, JC, JZ, OUT.
  - 4 cycles: LDA, STA.
  - 5 cycles: ADD, SUB.
  - HLT: halts at the end of its T2.
- Jumps: the new PC is captured at the end of T2, and the next T0 puts the target on the bus.
- Flags are sampled in T2 of JC/JZ. Flags written by a preceding ADD/SUB in its T4 are already visible.
- Halted: `step` holds at 2 and outputs stay 0. Only `rst` leaves this state.
- Reset asserted mid-instruction aborts it immediately. No partial strobes occur after the asynchronous assert.

## Configuration
- `CU_COND_JUMP_EN` defined: JC and JZ are decoded as specified above.
- `CU_COND_JUMP_EN` undefined: opcodes 0111 and 1000 decode as NOP (3 cycles, no strobes), and `flag_carry`/`flag_zero` are unused.

## Structure
- Shared package `cu_pkg`:
  - opcode constants (`OP_NOP`..`OP_HLT`);
  - T-state constants `T0`..`T4`;
  - packed control-word bit indices and a control-word typedef.
- Sub-module `cu_decoder`: purely combinational mapping of (step, opcode, flags) to a control word plus a `last_step` flag.
- `control_unit` itself holds the step counter, the halt latch, and the reset/halt output gating.

## Test plan
- Reset: hold `rst` 3 cycles, then release → all outputs 0 during reset; first cycle after release has `pc_enable`=`mar_load`=1 and `step`=0.
- LDI: feed opcode 0101 → T1 has `pc_inc`=1, T2 has `ir_enable`=`a_load`=1, next cycle is T0; 3 cycles total.
- ADD then SUB: feed 0010 then 0011 → 5 cycles each; `alu_sub`=0 in the first T4 and 1 in the second; `flags_load`=1 in both T4s.
- JZ: opcode 1000 with `flag_zero`=1 → `pc_load`=1 in T2. With `flag_zero`=0 → no strobe in T2. With the macro undefined → no strobe in either case.
- HLT: feed 1111 → `halted`=1 after T2; 10 further cycles show `step`=2 and all strobes 0; `rst` clears it.
- Reset mid-ADD: assert `rst` during T3 → outputs drop to 0 the same cycle; after release, execution resumes at T0.
- Throughout all scenarios: assert at most one bus driver per cycle, and never `pc_load` together with `pc_inc`.
